// File: rtl/weapons_pkg.sv
// Shared constants for the weapons fire scheduler: FSM state codes, the arming
// mode, the fire-error codes and the burst length used under WEAPONS_BURST_EN.
package weapons_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FIRE     = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;
  localparam logic [1:0] ST_RELOAD   = 2'd3;

  localparam logic [3:0] ATTACK_MODE = 4'b0010;

  localparam logic [1:0] ERR_NOT_ARMED = 2'b01;
  localparam logic [1:0] ERR_NO_AMMO   = 2'b10;

  localparam int BURST_LEN = 3;

endpackage

// File: rtl/weapons_fire_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches req upward from the pointer with wrap-around and
// moves the pointer past the granted turret when the advance strobe fires.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_adv,
  input  logic [NREQ-1:0] i_adv_grant,
  output logic [NREQ-1:0] o_winner
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_adv_idx;
  logic [NREQ-1:0] w_winner;
  logic            w_found;
  int              w_j;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = 32'(r_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!w_found && i_req[w_j]) begin
        w_winner[w_j] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  always_comb begin
    w_adv_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (i_adv_grant[k]) w_adv_idx = PW'(k);
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (32'(w_adv_idx) == NREQ - 1) ? '0 : w_adv_idx + PW'(1);
    end
  end

  assign o_winner = w_winner;

endmodule

// File: rtl/weapons_fire_scheduler.sv
// Shared-magazine fire scheduler: arming gate, round-robin grants, ammo debit,
// cooldown and reload sequencing. Define WEAPONS_BURST_EN for 3-shot bursts.
module weapons_fire_scheduler
  import weapons_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 9,
  parameter int CDW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      mode,
  input  logic [NREQ-1:0] req,
  input  logic [AW-1:0]   rate,
  input  logic [CDW-1:0]  cooldown,
  input  logic            reload_req,
  input  logic [AW-1:0]   reload_amt,
  input  logic            cfg_load,
  input  logic [AW-1:0]   cfg_cap,
  output logic [NREQ-1:0] grant,
  output logic            fire_pulse,
  output logic [AW-1:0]   ammo,
  output logic            busy,
  output logic            error,
  output logic [1:0]      err_code
);

  logic [1:0]      r_state, w_next;
  logic [AW-1:0]   r_ammo, r_cap;
  logic [CDW-1:0]  r_cnt;
  logic [NREQ-1:0] r_grant;
  logic            r_fire, r_busy, r_error;
  logic [1:0]      r_err_code;

  logic [NREQ-1:0] w_arb_win;
  logic            w_adv, w_more;
  logic [AW:0]     w_reload_sum;
  logic [AW-1:0]   w_reload_val, w_ammo_after;

`ifdef WEAPONS_BURST_EN
  logic [1:0] r_burst;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req),
    .i_adv      (w_adv),
    .i_adv_grant(r_grant),
    .o_winner   (w_arb_win)
  );

  // Reload saturates at the capacity; the sum is one bit wider to catch overflow.
  assign w_reload_sum = {1'b0, r_ammo} + {1'b0, reload_amt};
  assign w_reload_val = (w_reload_sum > {1'b0, r_cap}) ? r_cap : w_reload_sum[AW-1:0];
  assign w_ammo_after = r_ammo - rate;

`ifdef WEAPONS_BURST_EN
  assign w_more = (r_burst < 2'(BURST_LEN - 1)) && (w_ammo_after >= rate);
`else
  assign w_more = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!cfg_load) begin
          if (reload_req)
            w_next = ST_RELOAD;
          else if (|req && mode == ATTACK_MODE && r_ammo >= rate)
            w_next = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (w_more)              w_next = ST_FIRE;
        else if (cooldown == '0) w_next = ST_IDLE;
        else                     w_next = ST_COOLDOWN;
      end
      ST_COOLDOWN: if (r_cnt <= CDW'(1)) w_next = ST_IDLE;
      default: if (!reload_req || w_reload_val == r_cap) w_next = ST_IDLE;
    endcase
  end

  assign w_adv = (r_state == ST_FIRE) && (w_next != ST_FIRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ammo     <= '0;
      r_cap      <= '1;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_fire     <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
`ifdef WEAPONS_BURST_EN
      r_burst    <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_error <= 1'b0;
      r_grant <= '0;
      r_fire  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_load) begin
            r_cap <= cfg_cap;
            if (r_ammo > cfg_cap) r_ammo <= cfg_cap;
          end else if (!reload_req && |req) begin
            if (mode != ATTACK_MODE) begin
              r_error    <= 1'b1;
              r_err_code <= ERR_NOT_ARMED;
            end else if (r_ammo < rate) begin
              r_error    <= 1'b1;
              r_err_code <= ERR_NO_AMMO;
            end else begin
              r_grant <= w_arb_win;
              r_fire  <= 1'b1;
`ifdef WEAPONS_BURST_EN
              r_burst <= '0;
`endif
            end
          end
        end
        ST_FIRE: begin
          r_ammo <= w_ammo_after;
          if (w_next == ST_FIRE) begin
            r_grant <= r_grant;
            r_fire  <= 1'b1;
`ifdef WEAPONS_BURST_EN
            r_burst <= r_burst + 2'd1;
`endif
          end else if (w_next == ST_COOLDOWN) begin
            r_cnt <= cooldown;
          end
        end
        ST_COOLDOWN: r_cnt  <= r_cnt - CDW'(1);
        default:     r_ammo <= w_reload_val;
      endcase
    end
  end

  assign grant      = r_grant;
  assign fire_pulse = r_fire;
  assign ammo       = r_ammo;
  assign busy       = r_busy;
  assign error      = r_error;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_weapons_fire_scheduler.sv
// Directed bench for weapons_fire_scheduler: expected grants go into a queue as
// requests are driven and are popped when fire_pulse appears.
module tb_weapons_fire_scheduler;

  localparam int NREQ = 4;
  localparam int AW   = 9;
  localparam int CDW  = 4;

`ifdef WEAPONS_BURST_EN
  localparam int EXP_PULSES = 2;
  localparam int EXP_LEFT   = 5;
`else
  localparam int EXP_PULSES = 1;
  localparam int EXP_LEFT   = 15;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      mode;
  logic [NREQ-1:0] req;
  logic [AW-1:0]   rate;
  logic [CDW-1:0]  cooldown;
  logic            reload_req;
  logic [AW-1:0]   reload_amt;
  logic            cfg_load;
  logic [AW-1:0]   cfg_cap;
  logic [NREQ-1:0] grant;
  logic            fire_pulse;
  logic [AW-1:0]   ammo;
  logic            busy;
  logic            error;
  logic [1:0]      err_code;

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [NREQ-1:0] exp_q[$];
  int              n;
  int              pulses;
  int              m_ammo;

  weapons_fire_scheduler #(.NREQ(NREQ), .AW(AW), .CDW(CDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .req       (req),
    .rate      (rate),
    .cooldown  (cooldown),
    .reload_req(reload_req),
    .reload_amt(reload_amt),
    .cfg_load  (cfg_load),
    .cfg_cap   (cfg_cap),
    .grant     (grant),
    .fire_pulse(fire_pulse),
    .ammo      (ammo),
    .busy      (busy),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(output int cycles);
    cycles = 0;
    while (!fire_pulse && cycles < 12) begin
      tick();
      cycles++;
    end
    check("pulse_seen", {31'd0, fire_pulse}, 32'd1);
  endtask

  task automatic check_grant(input string tag);
    logic [NREQ-1:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check(tag, {28'd0, grant}, {28'd0, exp});
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 12) begin
      tick();
      c++;
    end
    check("back_to_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; mode = 4'd0; req = '0; rate = '0; cooldown = '0;
    reload_req = 1'b0; reload_amt = '0; cfg_load = 1'b0; cfg_cap = '0;
    tick(); tick();
    check("rst_ammo", {23'd0, ammo}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_fire", {31'd0, fire_pulse}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    rst = 1'b1;
    tick();

    // Capacity 300, then reload 100 per cycle until full.
    cfg_load = 1'b1; cfg_cap = 9'd300;
    tick();
    cfg_load = 1'b0;
    check("cfg_ammo_kept", {23'd0, ammo}, 32'd0);
    reload_amt = 9'd100; reload_req = 1'b1;
    tick();
    check("reload_busy", {31'd0, busy}, 32'd1);
    tick(); check("reload_100", {23'd0, ammo}, 32'd100);
    tick(); check("reload_200", {23'd0, ammo}, 32'd200);
    tick(); check("reload_300", {23'd0, ammo}, 32'd300);
    check("reload_exit_busy", {31'd0, busy}, 32'd0);
    reload_req = 1'b0;

    // Round-robin between turrets 0 and 2 with cooldown 3.
    m_ammo = 300;
    mode = 4'b0010; rate = 9'd10; cooldown = 4'd3;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0100); exp_q.push_back(4'b0001);
    req = 4'b0101;
    for (int s = 0; s < 3; s++) begin
      wait_pulse(n);
      check("rr_spacing", n, (s == 0) ? 1 : 4);
      check_grant("rr_grant");
      tick();
      m_ammo = m_ammo - 10;
      check("rr_ammo", {23'd0, ammo}, m_ammo);
      check("rr_pulse_one_cycle", {31'd0, fire_pulse}, 32'd0);
      if (s == 2) req = '0;
    end
    wait_idle();

    // Not armed: error every cycle, no grant.
    mode = 4'b0001; req = 4'b0001;
    tick();
    check("na_error", {31'd0, error}, 32'd1);
    check("na_code", {30'd0, err_code}, 32'd1);
    check("na_grant", {28'd0, grant}, 32'd0);
    tick();
    check("na_error_repeat", {31'd0, error}, 32'd1);
    check("na_no_fire", {31'd0, fire_pulse}, 32'd0);
    req = '0;
    tick();
    check("na_error_drop", {31'd0, error}, 32'd0);
    check("na_code_hold", {30'd0, err_code}, 32'd1);
    check("na_ammo", {23'd0, ammo}, m_ammo);

    // Insufficient ammo after shrinking capacity to 5.
    cfg_load = 1'b1; cfg_cap = 9'd5;
    tick();
    cfg_load = 1'b0;
    check("cfg_clamp_5", {23'd0, ammo}, 32'd5);
    mode = 4'b0010; req = 4'b1000;
    tick();
    check("noammo_error", {31'd0, error}, 32'd1);
    check("noammo_code", {30'd0, err_code}, 32'd2);
    check("noammo_no_fire", {31'd0, fire_pulse}, 32'd0);
    tick();
    check("noammo_error_repeat", {31'd0, error}, 32'd1);
    req = '0; cfg_load = 1'b1; cfg_cap = 9'd511;
    tick();
    cfg_load = 1'b0;
    check("cfg_grow_keeps", {23'd0, ammo}, 32'd5);
    reload_amt = 9'd10; reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    tick();
    check("reload_15", {23'd0, ammo}, 32'd15);
    exp_q.push_back(4'b1000);
    req = 4'b1000;
    wait_pulse(n);
    check("t3_latency", n, 1);
    check_grant("t3_grant");
    tick();
    req = '0;
    check("t3_ammo", {23'd0, ammo}, 32'd5);
    wait_idle();

    // Reload wins over a simultaneous request; then clamp via cfg_load.
    reload_amt = 9'd115; reload_req = 1'b1; req = 4'b0001;
    tick();
    check("rl_pri_busy", {31'd0, busy}, 32'd1);
    check("rl_pri_grant", {28'd0, grant}, 32'd0);
    check("rl_pri_error", {31'd0, error}, 32'd0);
    reload_req = 1'b0; req = '0;
    tick();
    check("rl_pri_ammo", {23'd0, ammo}, 32'd120);
    check("rl_pri_fire", {31'd0, fire_pulse}, 32'd0);
    cfg_load = 1'b1; cfg_cap = 9'd50;
    tick();
    cfg_load = 1'b0;
    check("cfg_clamp_50", {23'd0, ammo}, 32'd50);
    reload_amt = 9'd100; reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    tick();
    check("reload_saturate_50", {23'd0, ammo}, 32'd50);

    // Asynchronous reset in the middle of COOLDOWN.
    rate = 9'd10; cooldown = 4'd3;
    exp_q.push_back(4'b0010);
    req = 4'b0010;
    wait_pulse(n);
    check_grant("pre_rst_grant");
    tick();
    req = '0;
    check("pre_rst_ammo", {23'd0, ammo}, 32'd40);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ammo", {23'd0, ammo}, 32'd0);
    check("arst_grant", {28'd0, grant}, 32'd0);
    check("arst_fire", {31'd0, fire_pulse}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Pointer back at 0; with ammo 25 the burst build fires twice.
    reload_amt = 9'd25; reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    tick();
    check("post_rst_reload", {23'd0, ammo}, 32'd25);
    cooldown = 4'd0;
    exp_q.push_back(4'b0001);
    req = 4'b1111;
    wait_pulse(n);
    check("post_rst_latency", n, 1);
    check_grant("post_rst_winner");
    req = '0;
    pulses = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (fire_pulse) pulses++;
    end
    check("burst_pulses", pulses, EXP_PULSES);
    check("burst_ammo", {23'd0, ammo}, EXP_LEFT);

    // Reset capacity is 511: reload saturates there.
    reload_amt = 9'd300; reload_req = 1'b1;
    tick();
    tick();
    check("cap_reload_1", {23'd0, ammo}, EXP_LEFT + 300);
    reload_req = 1'b0;
    tick();
    check("cap_511", {23'd0, ammo}, 32'd511);
    check("cap_exit_busy", {31'd0, busy}, 32'd0);

    // rate 0: shot fires, ammo unchanged.
    rate = '0;
    exp_q.push_back(4'b0100);
    req = 4'b0100;
    wait_pulse(n);
    check("rate0_latency", n, 1);
    check_grant("rate0_grant");
    req = '0;
    tick();
    check("rate0_ammo", {23'd0, ammo}, 32'd511);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weapons_fire_scheduler.md
Name: weapons_fire_scheduler

Overview:
Arbitration and sequencing controller for the shared ammo magazine of the weapons subsystem. Multiple turret requesters share one magazine. The block gates firing on attack mode, grants shots round-robin, debits ammo per shot and enforces a programmable cooldown. It also sequences magazine reloads and reports fire errors to the command module.

Parameters:
NREQ, 4, number of turret requesters
AW, 9, ammo count width
CDW, 4, cooldown counter width
ATTACK_MODE, 4'b0010, mode code that arms the weapons

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
mode  input  4  current ship mode
req  input  NREQ  per-turret fire request, level
rate  input  AW  ammo consumed per shot
cooldown  input  CDW  idle cycles enforced after each shot
reload_req  input  1  reload request, level
reload_amt  input  AW  ammo added per reload cycle
cfg_load  input  1  load new magazine capacity
cfg_cap  input  AW  capacity value for cfg_load
grant  output  NREQ  one-hot, asserted for the FIRE cycle
fire_pulse  output  1  one-cycle shot strobe
ammo  output  AW  current ammo count
busy  output  1  state != IDLE
error  output  1  one-cycle error strobe
err_code  output  2  01 = not armed, 10 = insufficient ammo; holds until next error

Behaviour:
- Reset (rst=0, async): state=IDLE, ammo=0, cap={AW{1'b1}}, rr pointer=0, cooldown count=0; all outputs 0, err_code=00. grant and fire_pulse drop immediately, including mid-operation.
- States: IDLE, FIRE, COOLDOWN, RELOAD. All outputs are registered.
- IDLE, priority order:
  - reload_req=1 -> RELOAD. Any pending req is ignored with no error.
  - |req and mode!=ATTACK_MODE -> error=1, err_code=01, stay IDLE.
  - |req and ammo<rate -> error=1, err_code=10, stay IDLE.
  - |req otherwise -> latch the round-robin winner, go to FIRE.
  - An error re-pulses every cycle while the request and the failing condition persist.
- FIRE, 1 cycle: grant=winner, fire_pulse=1, ammo<=ammo-rate (new value visible the next cycle). rr pointer<=(winner+1) mod NREQ. Next state is COOLDOWN with count=cooldown, or IDLE if cooldown==0.
- COOLDOWN: decrement count each cycle; at count==1 go to IDLE. Requests, mode changes and reload_req are not acted on until IDLE.
- Shot spacing: the minimum from one fire_pulse to the next is 2+cooldown cycles. Request-to-grant latency is 1 cycle.
- Round-robin: search req from the pointer upward with wrap. The first set bit wins.
- RELOAD: each cycle ammo<=min(ammo+reload_amt, cap), computed at AW+1 bits. Return to IDLE when reload_req=0 or the updated ammo==cap. reload_amt=0 with reload_req held stays in RELOAD.
- cfg_load is honoured only in IDLE and has priority over arbitration that cycle. It sets cap<=cfg_cap; if ammo>cfg_cap, ammo<=cfg_cap. cfg_load in any other state is ignored.
- rate=0 is legal: the shot fires and ammo is unchanged.

Optional Feature:
WEAPONS_BURST_EN
- Defined: a grant holds FIRE for up to BURST_LEN=3 consecutive cycles to the same winner. Each cycle pulses fire_pulse and debits rate. The burst ends early if remaining ammo<rate, with no error. Cooldown applies once, after the burst.
- Undefined: single-shot FIRE as above.

Decomposition:
- Package weapons_pkg holds: the state enum, ATTACK_MODE, the ERR_NOT_ARMED/ERR_NO_AMMO codes, and BURST_LEN.
- Sub-module rr_arbiter (NREQ) contains the pointer register and the wrap-around search. It outputs the one-hot winner and takes an advance strobe.

Test Plan:
1. Reset, cfg_load cap=300, reload_req=1 with reload_amt=100 -> ammo 100, 200, 300; RELOAD exits at 300 and busy falls.
2. mode=0010, ammo=300, rate=10, cooldown=3, req=4'b0101 held -> grants 0001, 0100, 0001, five cycles apart; ammo 290, 280, 270.
3. mode=0001, req=0001 -> no grant, error pulses each cycle, err_code=01, ammo unchanged.
4. mode=0010, ammo=5, rate=10, req=1000 -> err_code=10, no fire_pulse. Then reload to 15 -> grant 1000, ammo=5.
5. reload_req and req asserted together in IDLE -> RELOAD entered, no grant, no error. Also: cfg_load cap=50 with ammo=120 -> ammo=50.
6. rst low during COOLDOWN -> asynchronous return to IDLE, ammo=0, grant=0, cap=511, next winner req[0]. With WEAPONS_BURST_EN: ammo=25, rate=10 -> two fire_pulses, ammo=5.
